// File: rtl/btn_pkg.sv
// btn_pkg: shared state encodings and counter-width helper for btn_repeat
package btn_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_DELAY = 2'd1, ST_REPEAT = 2'd2} state_t;
  function automatic int cnt_width(input int h, input int r);
    int m;
    m = h > r ? h : r;
    return $clog2(m) < 1 ? 1 : $clog2(m);
  endfunction
endpackage

// File: rtl/btn_repeat.sv
// btn_repeat: turns a debounced button level into press / auto-repeat / release strobes
module btn_repeat
  import btn_pkg::*;
#(
  parameter int HOLD_DELAY    = 50000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btnin,
  input  logic i_repeat_en,
  output logic o_press,
  output logic o_rpt,
  output logic o_pulse,
  output logic o_release,
  output logic o_held
);
  localparam int CW = cnt_width(HOLD_DELAY, REPEAT_PERIOD);
  localparam logic [CW-1:0] H_LAST = CW'(HOLD_DELAY - 1);
  localparam logic [CW-1:0] R_LAST = CW'(REPEAT_PERIOD - 1);
  state_t r_state, w_nstate;
  logic [CW-1:0] r_cnt, w_ncnt;
  logic w_press, w_rpt, w_release;
  logic r_press, r_rpt, r_pulse, r_release, r_held;
  always_comb begin
    w_nstate  = r_state;
    w_ncnt    = r_cnt;
    w_press   = 1'b0;
    w_rpt     = 1'b0;
    w_release = 1'b0;
    case (r_state)
      ST_IDLE:
        if (i_btnin) begin
          w_nstate = ST_DELAY;
          w_ncnt   = '0;
          w_press  = 1'b1;
        end
      ST_DELAY:
        if (!i_btnin) begin
          w_nstate  = ST_IDLE;
          w_ncnt    = '0;
          w_release = 1'b1;
        end else if (r_cnt == H_LAST) begin
          // without repeat_en the counter parks at the compare value
          if (i_repeat_en) begin
            w_nstate = ST_REPEAT;
            w_ncnt   = '0;
            w_rpt    = 1'b1;
          end
        end else w_ncnt = r_cnt + 1'b1;
      ST_REPEAT:
        if (!i_btnin) begin
          w_nstate  = ST_IDLE;
          w_ncnt    = '0;
          w_release = 1'b1;
        end else if (i_repeat_en) begin
          w_ncnt = r_cnt == R_LAST ? '0 : r_cnt + 1'b1;
          w_rpt  = r_cnt == R_LAST;
        end
      default: begin
        w_nstate = ST_IDLE;
        w_ncnt   = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_press   <= 1'b0;
      r_rpt     <= 1'b0;
      r_pulse   <= 1'b0;
      r_release <= 1'b0;
      r_held    <= 1'b0;
    end else begin
      r_state   <= w_nstate;
      r_cnt     <= w_ncnt;
      r_press   <= w_press;
      r_rpt     <= w_rpt;
      r_pulse   <= w_press | w_rpt;
      r_release <= w_release;
      r_held    <= w_nstate != ST_IDLE;
    end
  end
  assign o_press   = r_press;
  assign o_rpt     = r_rpt;
  assign o_pulse   = r_pulse;
  assign o_release = r_release;
  assign o_held    = r_held;
endmodule

// File: tb/tb_btn_repeat.sv
// tb_btn_repeat: vector-table and directed checks of btn_repeat (H=4,R=3) plus an H=1,R=1 instance
module tb_btn_repeat;
  logic clk = 1'b0, reset, btnin, repeat_en;
  logic press, rpt, pulse, rel, held;
  logic press1, rpt1, pulse1, rel1, held1;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  btn_repeat #(.HOLD_DELAY(4), .REPEAT_PERIOD(3)) dut (
    .clk(clk), .reset(reset), .i_btnin(btnin), .i_repeat_en(repeat_en),
    .o_press(press), .o_rpt(rpt), .o_pulse(pulse), .o_release(rel), .o_held(held)
  );

  btn_repeat #(.HOLD_DELAY(1), .REPEAT_PERIOD(1)) dut1 (
    .clk(clk), .reset(reset), .i_btnin(btnin), .i_repeat_en(repeat_en),
    .o_press(press1), .o_rpt(rpt1), .o_pulse(pulse1), .o_release(rel1), .o_held(held1)
  );

  // expected outputs packed as {press, rpt, pulse, release, held}
  typedef struct {
    logic rst;
    logic btn;
    logic en;
    logic [4:0] exp;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic r, input logic b, input logic e, input logic [4:0] x, input int n = 1);
    vec_t v;
    v.rst = r; v.btn = b; v.en = e; v.exp = x;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  task automatic step(input logic r, input logic b, input logic e);
    @(negedge clk);
    reset = r; btnin = b; repeat_en = e;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [4:0] act, input logic [4:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got {press,rpt,pulse,release,held}=%b expected %b", nm, act, exp);
    end
  endtask

  initial begin
    reset = 1'b1; btnin = 1'b0; repeat_en = 1'b1;
    // reset, then idle
    add(1, 0, 1, 5'b00000, 3);
    add(0, 0, 1, 5'b00000, 10);
    // full hold with repeats at edges 4, 7, 10, release at 12
    add(0, 1, 1, 5'b10101);
    add(0, 1, 1, 5'b00001, 3);
    add(0, 1, 1, 5'b01101);
    add(0, 1, 1, 5'b00001, 2);
    add(0, 1, 1, 5'b01101);
    add(0, 1, 1, 5'b00001, 2);
    add(0, 1, 1, 5'b01101);
    add(0, 1, 1, 5'b00001);
    add(0, 0, 1, 5'b00010);
    add(0, 0, 1, 5'b00000, 2);
    // release lands on the edge a repeat would fire
    add(0, 1, 1, 5'b10101);
    add(0, 1, 1, 5'b00001, 3);
    add(0, 1, 1, 5'b01101);
    add(0, 1, 1, 5'b00001, 2);
    add(0, 0, 1, 5'b00010);
    add(0, 0, 1, 5'b00000);
    // repeat disabled in DELAY, enabled at edge 10, paused in REPEAT at 17..19
    add(0, 1, 0, 5'b10101);
    add(0, 1, 0, 5'b00001, 9);
    add(0, 1, 1, 5'b01101);
    add(0, 1, 1, 5'b00001, 2);
    add(0, 1, 1, 5'b01101);
    add(0, 1, 1, 5'b00001, 2);
    add(0, 1, 1, 5'b01101);
    add(0, 1, 0, 5'b00001, 3);
    add(0, 1, 1, 5'b00001, 2);
    add(0, 1, 1, 5'b01101);
    add(0, 0, 1, 5'b00010);
    // single-edge press
    add(0, 1, 1, 5'b10101);
    add(0, 0, 1, 5'b00010);
    add(0, 0, 1, 5'b00000);
    // reset mid-hold, released with button still down
    add(0, 1, 1, 5'b10101);
    add(0, 1, 1, 5'b00001, 3);
    add(0, 1, 1, 5'b01101);
    add(1, 1, 1, 5'b00000);
    add(0, 1, 1, 5'b10101);
    add(0, 1, 1, 5'b00001, 3);
    add(0, 1, 1, 5'b01101);
    add(0, 0, 1, 5'b00010);
    add(0, 0, 1, 5'b00000, 2);

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].btn, vecs[i].en);
      chk($sformatf("vec%0d", i), {press, rpt, pulse, rel, held}, vecs[i].exp);
    end

    // H=1,R=1: repeat every cycle after the press, release beats rpt
    step(0, 1, 1);
    chk("h1_press", {press1, rpt1, pulse1, rel1, held1}, 5'b10101);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 1);
      chk($sformatf("h1_rpt%0d", i), {press1, rpt1, pulse1, rel1, held1}, 5'b01101);
    end
    step(0, 1, 0);
    chk("h1_paused", {press1, rpt1, pulse1, rel1, held1}, 5'b00001);
    step(0, 1, 1);
    chk("h1_resume", {press1, rpt1, pulse1, rel1, held1}, 5'b01101);
    step(0, 0, 1);
    chk("h1_release", {press1, rpt1, pulse1, rel1, held1}, 5'b00010);
    step(0, 0, 1);
    chk("h1_idle", {press1, rpt1, pulse1, rel1, held1}, 5'b00000);

    // H=1 with repeat disabled: press then held only
    step(0, 1, 0);
    chk("h1_noen_press", {press1, rpt1, pulse1, rel1, held1}, 5'b10101);
    step(0, 1, 0);
    chk("h1_noen_hold", {press1, rpt1, pulse1, rel1, held1}, 5'b00001);
    step(1, 1, 0);
    chk("h1_reset", {press1, rpt1, pulse1, rel1, held1}, 5'b00000);
    step(0, 0, 0);
    chk("h1_after_reset", {press1, rpt1, pulse1, rel1, held1}, 5'b00000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
